pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Power-on and lock-loss reset sequencer that sits directly downstream of the system PLL wrapper. It drives the PLL's `rst` input and consumes its `locked` output. It requires `locked` to stay stable for a programmable time, then releases the memory, core and peripheral reset domains in a fixed staggered order. It runs on the free-running 50 MHz reference clock, so it keeps operating while the PLL outputs are absent or unstable.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset attempt (≥2).
- `LOCK_TIMEOUT`, 65536: cycles to wait for lock before re-resetting the PLL (≥2).
- `LOCK_STABLE_CYCLES`, 50000: cycles `locked` must stay high before any release (≥2).
- `STAGE_GAP`, 256: cycles between successive domain releases (≥2).

Ports:
- `clk`, in, 1: 50 MHz reference clock (same net as PLL `refclk`).
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: PLL `locked`. Asynchronous to `clk`; synchronized internally.
- `pll_rst`, out, 1: drives PLL `rst`.
- `rst_mem`, out, 1: memory-controller domain reset, active-high.
- `rst_core`, out, 1: CPU/core domain reset, active-high.
- `rst_periph`, out, 1: peripheral/video/audio domain reset, active-high.
- `ready`, out, 1: all domains released, system running.
- `lock_loss_count`, out, 8: saturating count of lock losses after the first release.

## Operation
- `pll_locked` passes through a 2-flop synchronizer, producing `locked_s`. Both flops reset to 0.
- One shared counter `cnt` is sized for the largest parameter. It is cleared on every state entry and incremented each cycle the state is held.
- A state entered at edge E with `cnt`=0 and a duration of N exits at edge E+N.
- States and transitions:
  - PLL_RESET:
    - Outputs: `pll_rst`=1, all domain resets = 1.
    - At `cnt`==`PLL_RST_CYCLES`-1, go to WAIT_LOCK.
  - WAIT_LOCK:
    - If `locked_s`=1, go to STABLE.
    - Else, at `cnt`==`LOCK_TIMEOUT`-1, go to PLL_RESET.
  - STABLE:
    - If `locked_s`=0, go to WAIT_LOCK.
    - Else, at `cnt`==`LOCK_STABLE_CYCLES`-1, go to REL_MEM.
  - REL_MEM: `rst_mem`=0. After `STAGE_GAP` cycles, go to REL_CORE.
  - REL_CORE: `rst_mem`=0, `rst_core`=0. After `STAGE_GAP` cycles, go to REL_PERIPH.
  - REL_PERIPH: all domain resets = 0. After `STAGE_GAP` cycles, go to RUN.
  - RUN: all domain resets = 0, `ready`=1.
- Lock loss handling:
  - Applies when `locked_s`=0 in REL_MEM, REL_CORE, REL_PERIPH or RUN.
  - On that edge the FSM goes to WAIT_LOCK, all domain resets go to 1, `ready` goes to 0, and `lock_loss_count` increments, saturating at 255.
  - A lock loss takes priority over the stage-gap expiry on the same edge.
- A drop in STABLE does not increment `lock_loss_count`.
- `pll_rst` is 1 only in PLL_RESET.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.

## Timing
- Reset values: state PLL_RESET, `cnt`=0, synchronizer=0, `pll_rst`=1, `rst_mem`=`rst_core`=`rst_periph`=1, `ready`=0, `lock_loss_count`=0.
- `rst` asserted mid-operation restores all reset values on the next edge, including clearing `lock_loss_count`. The sequence restarts from PLL_RESET.
- The last edge with `rst`=1 counts as edge 0, i.e. entry into PLL_RESET.
- `pll_locked` to FSM latency: a level present at edge k is acted on at edge k+2.
- Release order is strict: `rst_mem`, then `rst_core`, then `rst_periph`, then `ready`, each `STAGE_GAP` edges apart. No two of these release on the same edge.
- Assertion is simultaneous: on lock loss, all resets rise on one edge.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=64, `LOCK_STABLE_CYCLES`=16, `STAGE_GAP`=8.
1. Normal bring-up: `pll_locked`=1 throughout, `rst` released after edge 0.
   - `pll_rst` falls at edge 4; STABLE is entered at edge 5.
   - `rst_mem` falls at 21, `rst_core` at 29, `rst_periph` at 37, `ready` rises at 45.
   - `lock_loss_count` stays 0.
2. Lock timeout: `pll_locked`=0 throughout.
   - `pll_rst` is low on edges 4–67, high on edges 68–71, low again at 72.
   - The cycle repeats every 68 edges and no domain reset ever falls.
3. Lock loss in RUN: after scenario 1, `pll_locked`=0 at edge 50.
   - At edge 52, all three resets and `ready` change together (resets high, `ready` low) and `lock_loss_count`=1.
   - Restoring lock repeats the release sequence with identical spacing.
4. Glitch in STABLE: one-cycle low on `pll_locked` during STABLE.
   - FSM returns to WAIT_LOCK and the stable count restarts.
   - `lock_loss_count` is unchanged and `rst_mem` falls 16 edges after the re-entry into STABLE.
5. Saturation and mid-run reset: 300 lock-loss events from RUN.
   - `lock_loss_count` holds at 255.
   - Asserting `rst` for one cycle clears it to 0 and sets `pll_rst`=1 and all resets high on the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Reset sequencer downstream of the system PLL: pulses the PLL reset, qualifies
// lock for a programmable time, then releases memory, core and peripheral domains in order.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 50000,
    parameter int STAGE_GAP          = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_mem,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_ALL > 2) ? $clog2(MAX_ALL) : 1;

    localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_REL_MEM,
        S_REL_CORE,
        S_REL_PERIPH,
        S_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       sync_q;
    logic             locked_s;
    logic             loss;
    logic             pll_rst_nxt;
    logic             rst_mem_nxt;
    logic             rst_core_nxt;
    logic             rst_periph_nxt;
    logic             ready_nxt;
    logic [7:0]       count_nxt;

    // pll_locked comes from the PLL's own timing domain, so it is double-flopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign locked_s = sync_q[1];

    always_comb begin
        state_nxt = state;
        loss      = 1'b0;
        case (state)
            S_PLL_RESET: begin
                if (cnt == PRST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)             state_nxt = S_STABLE;
                else if (cnt == TMO_LAST) state_nxt = S_PLL_RESET;
            end
            S_STABLE: begin
                if (!locked_s)               state_nxt = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = S_REL_MEM;
            end
            // Once any domain is out of reset, a drop is a real lock loss and wins over gap expiry.
            S_REL_MEM: begin
                if (!locked_s) begin
                    loss      = 1'b1;
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = S_REL_CORE;
                end
            end
            S_REL_CORE: begin
                if (!locked_s) begin
                    loss      = 1'b1;
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = S_REL_PERIPH;
                end
            end
            S_REL_PERIPH: begin
                if (!locked_s) begin
                    loss      = 1'b1;
                    state_nxt = S_WAIT_LOCK;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    loss      = 1'b1;
                    state_nxt = S_WAIT_LOCK;
                end
            end
            default: begin
                state_nxt = S_PLL_RESET;
            end
        endcase
    end

    // RUN has no timeout, so its counter is frozen rather than left to wrap.
    always_comb begin
        cnt_nxt = cnt + CNT_W'(1);
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == S_RUN) begin
            cnt_nxt = cnt;
        end
    end

    always_comb begin
        pll_rst_nxt    = (state_nxt == S_PLL_RESET);
        rst_mem_nxt    = 1'b1;
        rst_core_nxt   = 1'b1;
        rst_periph_nxt = 1'b1;
        ready_nxt      = 1'b0;
        case (state_nxt)
            S_REL_MEM: begin
                rst_mem_nxt = 1'b0;
            end
            S_REL_CORE: begin
                rst_mem_nxt  = 1'b0;
                rst_core_nxt = 1'b0;
            end
            S_REL_PERIPH: begin
                rst_mem_nxt    = 1'b0;
                rst_core_nxt   = 1'b0;
                rst_periph_nxt = 1'b0;
            end
            S_RUN: begin
                rst_mem_nxt    = 1'b0;
                rst_core_nxt   = 1'b0;
                rst_periph_nxt = 1'b0;
                ready_nxt      = 1'b1;
            end
            default: begin
                rst_mem_nxt = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_nxt = lock_loss_count;
        if (loss && (lock_loss_count != 8'hFF)) begin
            count_nxt = lock_loss_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_PLL_RESET;
            cnt             <= '0;
            pll_rst         <= 1'b1;
            rst_mem         <= 1'b1;
            rst_core        <= 1'b1;
            rst_periph      <= 1'b1;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            pll_rst         <= pll_rst_nxt;
            rst_mem         <= rst_mem_nxt;
            rst_core        <= rst_core_nxt;
            rst_periph      <= rst_periph_nxt;
            ready           <= ready_nxt;
            lock_loss_count <= count_nxt;
        end
    end

endmodule
